mdr_mem_if: RTL and testbench

- Memory-side front end for the datapath bus: holds the MAR and MDR, and runs the read/write handshake with the external memory.
- Its MDR output feeds the bus mux MDR input (busi_mdr). It loads MAR and MDR from the bus output (buso) under control-unit strobes.
- A small FSM sequences one memory transaction at a time and signals completion to the control unit.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 32 +++
 rtl/mdr_mem_if.sv | 169 ++++++++++++++++
 tb/tb_mdr_mem_if.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-side front end: word widths,
// default parameters and the transaction FSM encoding.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned MEM_ADDR_W      = 9;
  localparam int unsigned MEM_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_e;

  // True while a memory transaction is outstanding
  function automatic logic is_wait(input mem_state_e s);
    return (s == RD_WAIT) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for the memory ack timeout: cleared outside a transaction,
// counts wait cycles, flags the last allowed cycle.
`timescale 1ns/1ps
module mem_timeout_ctr #(
  parameter int unsigned CYC = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  // Count wait cycles, saturating at the expiry value
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Last wait cycle: an edge here without ack ends the transaction
  assign expired_c = (cnt_q == CNT_W'(CYC - 1));

endmodule

// File: rtl/mdr_mem_if.sv
// MAR/MDR holder and memory read/write handshake sequencer.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mdr_mem_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = cpu_pkg::MEM_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = cpu_pkg::MEM_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              read,
  input  logic              write,
  output logic [WORD_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Elaboration guard on the timeout depth
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  mem_state_e        state_q, state_nxt;
  logic [ADDR_W-1:0] mar_q;
  logic [WORD_W-1:0] mdr_q;
  logic              in_wait;
  logic              rd_cap;
  logic              accept;
  logic              req_nxt, we_nxt, busy_nxt, done_nxt;

  assign in_wait = is_wait(state_q);
  assign mdr_out = mdr_q;

`ifdef MEM_TIMEOUT_EN
  logic expired_c;
  logic timeout;

  mem_timeout_ctr #(.CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .clr_n     (clr_n),
    .clear     (!in_wait),
    .en        (in_wait),
    .expired_c (expired_c)
  );
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state_q;
    rd_cap    = 1'b0;
    accept    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (read) begin
          state_nxt = RD_WAIT;
          accept    = 1'b1;
        end else if (write) begin
          state_nxt = WR_WAIT;
          accept    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          state_nxt = DONE;
          rd_cap    = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired_c) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
`endif
      end
      WR_WAIT: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired_c) begin
          state_nxt = DONE;
          timeout   = 1'b1;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_nxt  = is_wait(state_nxt);
    we_nxt   = (state_nxt == WR_WAIT);
    busy_nxt = req_nxt;
    done_nxt = (state_nxt == DONE);
  end

  // State and handshake output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mem_req <= req_nxt;
      mem_we  <= we_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // MAR/MDR: bus loads only outside a transaction; read data on ack
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (mar_in && !in_wait) begin
        mar_q <= bus_in[ADDR_W-1:0];
      end
      if (rd_cap) begin
        mdr_q <= mem_rdata;
      end else if (mdr_in && !in_wait) begin
        mdr_q <= bus_in;
      end
    end
  end

  // Memory-facing copies: track MAR/MDR when idle, frozen during a
  // transaction so a load coinciding with a request leaves the old values
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (!in_wait) begin
      mem_addr  <= mar_q;
      mem_wdata <= mdr_q;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Sticky timeout flag, cleared by the next accepted request
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed self-checking bench for mdr_mem_if.
`timescale 1ns/1ps
module tb_mdr_mem_if;
  import cpu_pkg::*;

  logic              clk;
  logic              clr_n;
  logic [WORD_W-1:0] bus_in;
  logic              mar_in, mdr_in, read, write;
  logic [WORD_W-1:0] mdr_out;
  logic [8:0]        mem_addr;
  logic              mem_req, mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  mdr_mem_if #(.ADDR_W(9), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus_in    (bus_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .read      (read),
    .write     (write),
    .mdr_out   (mdr_out),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    clr_n = 1'b0; bus_in = '0; mar_in = 0; mdr_in = 0; read = 0; write = 0;
    mem_rdata = '0; mem_ack = 0;
    #2;
    chk("rst_req",  32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_done", 32'(done),    32'h0);
    chk("rst_err",  32'(err),     32'h0);
    chk("rst_mdr",  mdr_out,      32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    #10 clr_n = 1'b1;

    // Zero-wait read
    bus_in = 32'h0000_0042; mar_in = 1;
    step();
    mar_in = 0; read = 1;
    step();
    chk("zr_req",  32'(mem_req), 32'h1);
    chk("zr_we",   32'(mem_we),  32'h0);
    chk("zr_busy", 32'(busy),    32'h1);
    chk("zr_addr", 32'(mem_addr), 32'h042);
    chk("zr_done0", 32'(done),   32'h0);
    read = 0; mem_rdata = 32'hCAFE_F00D; mem_ack = 1;
    step();
    mem_ack = 0;
    chk("zr_done", 32'(done),    32'h1);
    chk("zr_busy_d", 32'(busy),  32'h0);
    chk("zr_req_d", 32'(mem_req), 32'h0);
    chk("zr_mdr",  mdr_out,      32'hCAFE_F00D);
    step();
    chk("zr_done_end", 32'(done), 32'h0);

    // Three-wait write
    bus_in = 32'h1234_5678; mdr_in = 1;
    step();
    mdr_in = 0; write = 1;
    step();
    write = 0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_we",    32'(mem_we),  32'h1);
      chk("wr_req",   32'(mem_req), 32'h1);
      chk("wr_wdata", mem_wdata,    32'h1234_5678);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      mem_ack = (i == 3);
      step();
    end
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (i == 0) chk("wr_mdr", mdr_out, 32'h1234_5678);
      step();
    end
    chk("wr_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("wr_done_pulses", 32'(done_cnt), 32'd1);

    // Read and write together: read wins
    read = 1; write = 1;
    step();
    read = 0; write = 0;
    chk("rw_req", 32'(mem_req), 32'h1);
    chk("rw_we",  32'(mem_we),  32'h0);
    // MDR load during a transaction is ignored
    bus_in = 32'hFFFF_FFFF; mdr_in = 1;
    step();
    mdr_in = 0;
    chk("blk_mdr", mdr_out, 32'h1234_5678);
    mem_rdata = 32'hA5A5_0001; mem_ack = 1;
    step();
    chk("blk_done", 32'(done), 32'h1);
    chk("blk_mdr2", mdr_out,   32'hA5A5_0001);
    // Spurious ack in DONE then IDLE
    mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("sp_done", 32'(done),    32'h0);
    chk("sp_req",  32'(mem_req), 32'h0);
    chk("sp_mdr",  mdr_out,      32'hA5A5_0001);
    step();
    chk("sp_busy", 32'(busy),    32'h0);
    chk("sp_req2", 32'(mem_req), 32'h0);
    chk("sp_mdr2", mdr_out,      32'hA5A5_0001);
    mem_ack = 0;
    step();

    // Load coinciding with a write request: request uses old MDR
    bus_in = 32'h0000_0077; mdr_in = 1; write = 1;
    step();
    mdr_in = 0; write = 0;
    chk("co_we",    32'(mem_we), 32'h1);
    chk("co_wdata", mem_wdata,   32'hA5A5_0001);
    chk("co_mdr",   mdr_out,     32'h0000_0077);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("co_done", 32'(done), 32'h1);
    chk("co_mdr2", mdr_out,   32'h0000_0077);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 16 request cycles
    read = 1;
    step();
    read = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      done_cnt += int'(done);
      if (mem_req !== 1'b1) chk("to_req", 32'(mem_req), 32'h1);
      step();
    end
    chk("to_no_early_done", 32'(done_cnt), 32'd0);
    chk("to_done", 32'(done), 32'h1);
    chk("to_err",  32'(err),  32'h1);
    chk("to_mdr",  mdr_out,   32'h0000_0077);
    step();
    chk("to_err_sticky", 32'(err), 32'h1);
    read = 1;
    step();
    read = 0;
    chk("to_err_clr", 32'(err), 32'h0);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    chk("to_ok_done", 32'(done), 32'h1);
    chk("to_ok_err",  32'(err),  32'h0);
    step();
`else
    // No ack: keeps waiting, no error
    read = 1;
    step();
    read = 0;
    for (int i = 0; i < 20; i++) step();
    chk("nt_req",  32'(mem_req), 32'h1);
    chk("nt_busy", 32'(busy),    32'h1);
    chk("nt_err",  32'(err),     32'h0);
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    chk("nt_done", 32'(done), 32'h1);
    chk("nt_mdr",  mdr_out,   32'h0BAD_F00D);
    step();
`endif

    // Reset in the middle of a read
    bus_in = 32'h0000_01FF; mar_in = 1;
    step();
    mar_in = 0; read = 1;
    step();
    read = 0;
    chk("mr_req_pre", 32'(mem_req), 32'h1);
    #2 clr_n = 1'b0;
    #1;
    chk("mr_req",  32'(mem_req), 32'h0);
    chk("mr_busy", 32'(busy),    32'h0);
    chk("mr_done", 32'(done),    32'h0);
    chk("mr_mdr",  mdr_out,      32'h0);
    chk("mr_addr", 32'(mem_addr), 32'h0);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    #1 clr_n = 1'b1;
    step();
    mem_ack = 0;
    chk("mr_late_req",  32'(mem_req), 32'h0);
    chk("mr_late_done", 32'(done),    32'h0);
    chk("mr_late_mdr",  mdr_out,      32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
